// File: rtl/uart_rx_frame_if.sv
// Host-side bundle of the UART receiver: serial line in, pop strobe in,
// holding-register data and RX status out.
interface uart_rx_frame_if #(
  parameter int DATA_SIZE = 8
);
  logic                 serial_data_in;
  logic                 read_data;
  logic [DATA_SIZE-1:0] bus_data_out;
  logic [7:0]           RX_status_register;

  modport master (
    output serial_data_in,
    output read_data,
    input  bus_data_out,
    input  RX_status_register
  );

  modport slave (
    input  serial_data_in,
    input  read_data,
    output bus_data_out,
    output RX_status_register
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver with a one-entry holding register and an RX status
// register carrying per-entry parity/break/stop errors plus sticky overflow.
module uart_rx_frame #(
  parameter int DATA_SIZE  = 8,
  parameter int SYS_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int SAMPLE     = 16,
  parameter int BAUD_DVSR  = SYS_FREQ / (SAMPLE * BAUD_RATE),
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_frame_if.slave bus
);

  localparam int TW = (BAUD_DVSR > 2) ? $clog2(BAUD_DVSR) : 1;
  localparam int SW = $clog2(SAMPLE);
  localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BAUD_DVSR - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE - 1);
  localparam logic [SW-1:0] S_HALF = SW'(SAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_SIZE - 1);
  localparam logic          PEN    = (PARITY_EN != 0);
  localparam logic          ODD    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt_q;
  logic                 tick;
  state_e               state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 done_q, done_d;
  logic                 stop_err_q, stop_err_d;
  logic                 brk_q, brk_d;
  logic                 par_err_q, par_err_d;

  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 full_q, full_d;
  logic                 par_e_q, par_e_d;
  logic                 brk_e_q, brk_e_d;
  logic                 stop_e_q, stop_e_d;
  logic                 ovf_q, ovf_d;
  logic                 rnr_q, rnr_d;
  logic                 pop;

  assign rx_s = sync_q[1];
  assign tick = (tick_cnt_q == T_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      bit_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.serial_data_in};
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q    <= shreg_d;
    par_bit_q  <= par_bit_d;
    stop_err_q <= stop_err_d;
    brk_q      <= brk_d;
    par_err_q  <= par_err_d;
  end

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    done_d     = 1'b0;
    stop_err_d = stop_err_q;
    brk_d      = brk_q;
    par_err_d  = par_err_q;
    case (state_q)
      IDLE: if (tick && !rx_s) begin
        state_d = START;
        s_cnt_d = '0;
      end
      START: if (tick) begin
        if (s_cnt_q == S_HALF) begin
          s_cnt_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      DATA: if (tick) begin
        if (s_cnt_q == S_LAST) begin
          s_cnt_d = '0;
          shreg_d = {rx_s, shreg_q[DATA_SIZE-1:1]};
          if (bit_cnt_q == B_LAST) state_d = PEN ? PARITY : STOP;
          else                     bit_cnt_d = bit_cnt_q + 1'b1;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      PARITY: if (tick) begin
        if (s_cnt_q == S_LAST) begin
          s_cnt_d   = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      STOP: if (tick) begin
        if (s_cnt_q == S_LAST) begin
          s_cnt_d    = '0;
          done_d     = 1'b1;
          stop_err_d = ~rx_s;
          brk_d      = ~rx_s & (shreg_q == '0) & (~par_bit_q | ~PEN);
          par_err_d  = PEN & (((^shreg_q) ^ par_bit_q) != ODD);
          state_d    = rx_s ? IDLE : WAIT_HIGH;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a pop in the commit cycle frees the slot for the new frame.
  always_comb begin
    data_d   = data_q;
    full_d   = full_q;
    par_e_d  = par_e_q;
    brk_e_d  = brk_e_q;
    stop_e_d = stop_e_q;
    ovf_d    = ovf_q;
    rnr_d    = rnr_q;
    pop      = bus.read_data & full_q;
    if (bus.read_data && !full_q) rnr_d = 1'b1;
    if (pop) begin
      full_d   = 1'b0;
      par_e_d  = 1'b0;
      brk_e_d  = 1'b0;
      stop_e_d = 1'b0;
      ovf_d    = 1'b0;
      rnr_d    = 1'b0;
    end
    if (done_q) begin
      if (!full_q || pop) begin
        data_d   = shreg_q;
        full_d   = 1'b1;
        // A break frame carries no meaningful parity, so it is flagged too.
        par_e_d  = par_err_q | brk_q;
        brk_e_d  = brk_q;
        stop_e_d = stop_err_q;
      end else ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      full_q   <= 1'b0;
      par_e_q  <= 1'b0;
      brk_e_q  <= 1'b0;
      stop_e_q <= 1'b0;
      ovf_q    <= 1'b0;
      rnr_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      full_q   <= full_d;
      par_e_q  <= par_e_d;
      brk_e_q  <= brk_e_d;
      stop_e_q <= stop_e_d;
      ovf_q    <= ovf_d;
      rnr_q    <= rnr_d;
    end
  end

  assign bus.bus_data_out       = data_q;
  assign bus.RX_status_register = {rnr_q, ovf_q, stop_e_q, brk_e_q, par_e_q,
                                   ~full_q, full_q, 1'b0};

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 64 clk per bit: table of single frames
// followed by hand-written break, overflow, glitch, empty-read and reset sequences.
module tb_uart_rx_frame;

  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  uart_rx_frame_if #(.DATA_SIZE(8)) bus_if ();

  uart_rx_frame #(
    .DATA_SIZE (8),
    .SAMPLE    (16),
    .BAUD_DVSR (4),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [7:0] exp_status;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic line_bit(input logic b, input int clks);
    bus_if.serial_data_in = b;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par);
    line_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) line_bit(d[i], BIT_CLK);
    line_bit(par, BIT_CLK);
    line_bit(1'b1, BIT_CLK);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    @(posedge clk);
    #1 bus_if.read_data = 1'b1;
    @(posedge clk);
    #1 bus_if.read_data = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 8'h02};
    vecs[1] = '{8'h3C, 1'b1, 8'h0A};
    vecs[2] = '{8'h00, 1'b0, 8'h02};
    vecs[3] = '{8'hFF, 1'b1, 8'h0A};
    vecs[4] = '{8'h80, 1'b1, 8'h02};
    vecs[5] = '{8'h01, 1'b0, 8'h0A};

    bus_if.serial_data_in = 1'b1;
    bus_if.read_data      = 1'b0;
    reset                 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_status", bus_if.RX_status_register, 8'h04);
    check("reset_data", bus_if.bus_data_out, 8'h00);
    reset = 1'b0;
    line_bit(1'b1, 2 * BIT_CLK);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].par);
      settle();
      check($sformatf("vec%0d_data", i), bus_if.bus_data_out, vecs[i].data);
      check($sformatf("vec%0d_status", i), bus_if.RX_status_register, vecs[i].exp_status);
      pulse_read();
      check($sformatf("vec%0d_read_status", i), bus_if.RX_status_register, 8'h04);
      check($sformatf("vec%0d_read_data", i), bus_if.bus_data_out, vecs[i].data);
    end

    // Break: line low for 12 bit times yields exactly one frame.
    line_bit(1'b0, 12 * BIT_CLK);
    check("break_data", bus_if.bus_data_out, 8'h00);
    check("break_status", bus_if.RX_status_register, 8'h3A);
    line_bit(1'b1, 3 * BIT_CLK);
    check("break_no_second", bus_if.RX_status_register, 8'h3A);
    pulse_read();
    check("break_read_status", bus_if.RX_status_register, 8'h04);

    // Overflow: second frame dropped while the first is unread.
    send_frame(8'h11, 1'b0);
    line_bit(1'b1, 4);
    send_frame(8'h22, 1'b0);
    settle();
    check("ovf_data", bus_if.bus_data_out, 8'h11);
    check("ovf_status", bus_if.RX_status_register, 8'h42);
    pulse_read();
    check("ovf_read_status", bus_if.RX_status_register, 8'h04);
    check("ovf_read_data", bus_if.bus_data_out, 8'h11);

    // Short low glitch, then read while empty.
    line_bit(1'b0, 20);
    line_bit(1'b1, 3 * BIT_CLK);
    check("glitch_status", bus_if.RX_status_register, 8'h04);
    pulse_read();
    check("empty_read_status", bus_if.RX_status_register, 8'h84);

    // Reset in the middle of data bit 3 of 0x5A.
    line_bit(1'b0, BIT_CLK);
    line_bit(1'b0, BIT_CLK);
    line_bit(1'b1, BIT_CLK);
    line_bit(1'b0, BIT_CLK);
    line_bit(1'b1, BIT_CLK / 2);
    reset = 1'b1;
    bus_if.serial_data_in = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_status", bus_if.RX_status_register, 8'h04);
    check("midreset_data", bus_if.bus_data_out, 8'h00);
    reset = 1'b0;
    line_bit(1'b1, 2 * BIT_CLK);
    send_frame(8'h5A, 1'b0);
    settle();
    check("after_reset_data", bus_if.bus_data_out, 8'h5A);
    check("after_reset_status", bus_if.RX_status_register, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
